// File: rtl/miriscv_lsu.sv
// miriscv_lsu: load/store unit driving the core's fixed-latency data-memory port.
// Each aligned request runs IDLE -> ACCESS -> DONE (3 cycles, stall high for 2).
// Optional build macro MIRISCV_LSU_MISALIGN_EN: flags misaligned halfword/word
// requests with a one-cycle lsu_misalign_o pulse instead of issuing them.
module miriscv_lsu #(
  parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  size_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [31:0] data_q;
  logic [1:0]  off;
  logic        is_byte, is_half;
  logic        misaligned;
  logic        issue;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign off     = lsu_addr_i[1:0];
  // Size codes 011/110/111 fall through to word handling.
  assign is_byte = (lsu_size_i[1:0] == 2'b00);
  assign is_half = (lsu_size_i[1:0] == 2'b01);

`ifdef MIRISCV_LSU_MISALIGN_EN
  assign misaligned = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign issue       = (state_q == IDLE) & lsu_req_i & ~misaligned;
  assign data_addr_o = {lsu_addr_i[31:2], 2'b00};
  assign lsu_data_o  = data_q;

  // Next-state logic and all memory/core handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_d         = state_q;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'b0000;
    data_wdata_o    = 32'h0;
    lsu_stall_req_o = 1'b0;
    lsu_misalign_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && misaligned) begin
          lsu_misalign_o = 1'b1;
        end else if (lsu_req_i) begin
          data_req_o      = 1'b1;
          data_we_o       = lsu_we_i;
          lsu_stall_req_o = 1'b1;
          state_d         = ACCESS;
          if (!lsu_we_i) begin
            data_be_o = 4'b1111;
          end else if (is_byte) begin
            data_be_o    = 4'b0001 << off;
            data_wdata_o = {4{lsu_data_i[7:0]}};
          end else if (is_half) begin
            data_be_o    = off[1] ? 4'b1100 : 4'b0011;
            data_wdata_o = {2{lsu_data_i[15:0]}};
          end else begin
            data_be_o    = 4'b1111;
            data_wdata_o = lsu_data_i;
          end
        end
      end
      // Memory is already committed, so a dropped request is ignored here.
      ACCESS: begin
        lsu_stall_req_o = 1'b1;
        state_d         = DONE;
      end
      // The core advances at this edge; requests are not sampled in DONE.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    byte_sel = data_rdata_i[8*off_q +: 8];
    half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q[1:0])
      2'b00:   load_data = {{24{~size_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~size_q[2] & half_sel[15]}}, half_sel};
      default: load_data = data_rdata_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture access attributes when a request is issued.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      size_q <= 3'b000;
      we_q   <= 1'b0;
      off_q  <= 2'b00;
    end else if (issue) begin
      size_q <= lsu_size_i;
      we_q   <= lsu_we_i;
      off_q  <= off;
    end
  end

  // Load result register; only load completions update it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         data_q <= RESET_DATA;
    else if (state_q == ACCESS && !we_q)  data_q <= load_data;
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed testbench for miriscv_lsu with a small registered-read word memory.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [31:0] lsu_rdata;
  logic        stall, misalign;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int req_pulses = 0;
  int req_cycle = 0;
  int first_req_cycle;
  int pulses_before;

  logic [31:0] mem [0:15];

  miriscv_lsu dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wdata), .lsu_data_o(lsu_rdata),
    .lsu_stall_req_o(stall), .lsu_misalign_o(misalign),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: byte-enabled writes, read data valid the cycle after the request.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (data_req) begin
      data_rdata <= mem[data_addr[5:2]];
      if (data_we) begin
        for (int b = 0; b < 4; b++)
          if (data_be[b]) mem[data_addr[5:2]][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  always @(negedge clk) if (data_req) req_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access: issue cycle, ACCESS cycle, DONE cycle. Leaves lsu_req high.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_result);
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wd;
    @(negedge clk);
    req_cycle = cycle;
    check({tag, ".req"},   {31'b0, data_req}, 32'd1);
    check({tag, ".we"},    {31'b0, data_we}, {31'b0, we});
    check({tag, ".be"},    {28'b0, data_be}, {28'b0, exp_be});
    check({tag, ".addr"},  data_addr, {addr[31:2], 2'b00});
    check({tag, ".wdata"}, data_wdata, exp_wdata);
    check({tag, ".stall1"}, {31'b0, stall}, 32'd1);
    @(negedge clk);
    check({tag, ".req_acc"}, {31'b0, data_req}, 32'd0);
    check({tag, ".stall2"},  {31'b0, stall}, 32'd1);
    @(negedge clk);
    check({tag, ".stall_done"}, {31'b0, stall}, 32'd0);
    check({tag, ".req_done"},   {31'b0, data_req}, 32'd0);
    check({tag, ".result"},     lsu_rdata, exp_result);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state.
    #12;
    check("rst.stall", {31'b0, stall}, 32'd0);
    check("rst.req",   {31'b0, data_req}, 32'd0);
    check("rst.we",    {31'b0, data_we}, 32'd0);
    check("rst.be",    {28'b0, data_be}, 32'd0);
    check("rst.wdata", data_wdata, 32'h0);
    check("rst.mis",   {31'b0, misalign}, 32'd0);
    check("rst.data",  lsu_rdata, 32'h0);
    #6 rst_n = 1'b1;

    // Word store then load.
    access("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    access("lw",  1'b0, 3'b010, 32'h10, 32'h0,        4'b1111, 32'h0,        32'hDEADBEEF);
    // Byte store to the top lane; word 0x10 becomes 0xA5ADBEEF.
    access("sb",  1'b1, 3'b000, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF);
    access("lb",  1'b0, 3'b000, 32'h13, 32'h0,        4'b1111, 32'h0,        32'hFFFFFFA5);
    access("lbu", 1'b0, 3'b100, 32'h13, 32'h0,        4'b1111, 32'h0,        32'h000000A5);
    access("lb0", 1'b0, 3'b000, 32'h10, 32'h0,        4'b1111, 32'h0,        32'hFFFFFFEF);
    // Halfword store to the upper half; word 0x14 becomes 0x80010000.
    access("sh",  1'b1, 3'b001, 32'h16, 32'h00008001, 4'b1100, 32'h80018001, 32'h000000EF + 32'hFFFFFF00);
    access("lh",  1'b0, 3'b001, 32'h16, 32'h0,        4'b1111, 32'h0,        32'hFFFF8001);
    access("lhu", 1'b0, 3'b101, 32'h16, 32'h0,        4'b1111, 32'h0,        32'h00008001);
    access("sh0", 1'b1, 3'b001, 32'h14, 32'h0000C0DE, 4'b0011, 32'hC0DEC0DE, 32'h00008001);
    // Unlisted size code behaves as a word.
    access("l111", 1'b0, 3'b111, 32'h10, 32'h0,       4'b1111, 32'h0,        32'hA5ADBEEF);

    // Back-to-back: request held high across two loads.
    pulses_before = req_pulses;
    access("b2b1", 1'b0, 3'b010, 32'h14, 32'h0, 4'b1111, 32'h0, 32'h8001C0DE);
    first_req_cycle = req_cycle;
    access("b2b2", 1'b0, 3'b001, 32'h14, 32'h0, 4'b1111, 32'h0, 32'hFFFFC0DE);
    check("b2b.spacing", req_cycle - first_req_cycle, 32'd3);
    check("b2b.pulses",  req_pulses - pulses_before, 32'd2);
    @(posedge clk); #1 lsu_req = 1'b0;

    // Word load at an unaligned address.
    access("sw20", 1'b1, 3'b010, 32'h20, 32'h12345678, 4'b1111, 32'h12345678, 32'hFFFFC0DE);
    @(posedge clk); #1 lsu_req = 1'b0;
`ifdef MIRISCV_LSU_MISALIGN_EN
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'b010; lsu_addr = 32'h21;
    @(negedge clk);
    check("mis.req",   {31'b0, data_req}, 32'd0);
    check("mis.stall", {31'b0, stall}, 32'd0);
    check("mis.pulse", {31'b0, misalign}, 32'd1);
    @(posedge clk); #1 lsu_req = 1'b0;
    @(negedge clk);
    check("mis.clear", {31'b0, misalign}, 32'd0);
    check("mis.data",  lsu_rdata, 32'hFFFFC0DE);
`else
    access("lw21", 1'b0, 3'b010, 32'h21, 32'h0, 4'b1111, 32'h0, 32'h12345678);
    check("lw21.mis", {31'b0, misalign}, 32'd0);
    @(posedge clk); #1 lsu_req = 1'b0;
`endif

    // Asynchronous reset in the middle of ACCESS.
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'b010; lsu_addr = 32'h10;
    @(posedge clk); #2;
    check("mid.stall_pre", {31'b0, stall}, 32'd1);
    lsu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid.stall", {31'b0, stall}, 32'd0);
    check("mid.req",   {31'b0, data_req}, 32'd0);
    check("mid.data",  lsu_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Normal operation resumes after reset.
    access("post", 1'b0, 3'b010, 32'h10, 32'h0, 4'b1111, 32'h0, 32'hA5ADBEEF);
    @(posedge clk); #1 lsu_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
